mig_app_model: RTL and testbench

MIG_APP_MODEL -- requirements
Module: mig_app_model

---
 rtl/mig_app_model_if.sv | 35 +++
 rtl/mig_app_model.sv | 221 ++++++++++++++++++++++
 tb/tb_mig_app_model.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mig_app_model_if.sv
// Application-side bus of the MIG user-interface model: command channel,
// write-data channel, read-data channel and the calibration flag.
interface mig_app_model_if;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         init_calib_complete;

    // User logic side: issues commands and write beats, consumes read data.
    modport master (
        output app_addr, app_cmd, app_en,
        output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid, app_rd_data_end,
        input  init_calib_complete
    );

    // Memory model side.
    modport slave (
        input  app_addr, app_cmd, app_en,
        input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid, app_rd_data_end,
        output init_calib_complete
    );
endinterface

// File: rtl/mig_app_model.sv
// Behavioural model of a MIG application interface backed by a 128-bit-line
// memory: calibration delay, 2-entry write-data FIFO, write commands that may
// wait for their data, fixed-latency pipelined reads and optional app_rdy stalls.
module mig_app_model #(
    parameter int MEM_DEPTH    = 1024,
    parameter int CALIB_CYCLES = 16,
    parameter int RD_LATENCY   = 4,
    parameter int STALL_PERIOD = 0
) (
    input  logic           ui_clk,
    input  logic           ui_clk_sync_rst,
    mig_app_model_if.slave app
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(CALIB_CYCLES + 1);
    localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    // Command-channel state: ready for commands, or holding a write command
    // that arrived before its data beat.
    typedef enum logic {
        ST_READY,
        ST_WAIT_DATA
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_pend_line;
    logic [AW-1:0]   w_pend_line_next;

    logic [CW-1:0]   r_calib_cnt;
    logic            r_calib_done;
    logic            w_calib_next;
    logic [SW-1:0]   r_stall_cnt;
    logic [SW-1:0]   w_stall_cnt_next;
    logic            w_stall_next;
    logic            r_app_rdy;
    logic            w_app_rdy_next;

    logic [127:0]    r_fifo_data [2];
    logic [15:0]     r_fifo_mask [2];
    logic            r_fifo_wp;
    logic            r_fifo_rp;
    logic [1:0]      r_fifo_cnt;
    logic            w_fifo_empty;
    logic            w_push;
    logic            w_pop;

    logic [127:0]    r_mem [MEM_DEPTH];
    logic            w_commit;
    logic [AW-1:0]   w_commit_line;
    logic [127:0]    w_commit_data;
    logic [15:0]     w_commit_mask;

    logic            r_rd_vld [RD_LATENCY];
    logic [127:0]    r_rd_dat [RD_LATENCY];

    logic [AW-1:0]   w_line;
    logic            w_wdf_rdy;
    logic            w_beat;
    logic            w_cmd_acc;
    logic            w_wr_cmd;
    logic            w_rd_cmd;
    logic            w_unused;

    // Address offset bits, bits above the line index and the last-beat flag
    // carry no information for a single-beat, line-granular model.
    assign w_unused = ^{app.app_addr, app.app_wdf_end};

    assign w_line       = app.app_addr[4 +: AW];
    assign w_fifo_empty = (r_fifo_cnt == 2'd0);
    assign w_wdf_rdy    = r_calib_done && (r_fifo_cnt != 2'd2);
    assign w_beat       = app.app_wdf_wren && w_wdf_rdy;
    assign w_cmd_acc    = app.app_en && r_app_rdy;
    assign w_wr_cmd     = w_cmd_acc && (app.app_cmd == 3'b000);
    assign w_rd_cmd     = w_cmd_acc && (app.app_cmd == 3'b001);
    assign w_calib_next = r_calib_done || (r_calib_cnt == CW'(CALIB_CYCLES - 1));

    // Decide how this cycle's write command and data beat move data between
    // the FIFO, the pending-write slot and the memory.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves a signal unassigned (no latch inferred).
        w_state_next     = r_state;
        w_pend_line_next = r_pend_line;
        w_commit         = 1'b0;
        w_commit_line    = w_line;
        w_commit_data    = app.app_wdf_data;
        w_commit_mask    = app.app_wdf_mask;
        w_push           = 1'b0;
        w_pop            = 1'b0;
        case (r_state)
            ST_READY: begin
                w_push = w_beat;
                if (w_wr_cmd) begin
                    if (!w_fifo_empty) begin
                        // Oldest queued beat belongs to this command; a beat
                        // arriving now queues behind it on the same edge.
                        w_commit      = 1'b1;
                        w_pop         = 1'b1;
                        w_commit_data = r_fifo_data[r_fifo_rp];
                        w_commit_mask = r_fifo_mask[r_fifo_rp];
                    end else if (w_beat) begin
                        // Data and command in the same cycle: bypass the FIFO.
                        w_commit = 1'b1;
                        w_push   = 1'b0;
                    end else begin
                        w_state_next     = ST_WAIT_DATA;
                        w_pend_line_next = w_line;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (w_beat) begin
                    w_commit      = 1'b1;
                    w_commit_line = r_pend_line;
                    w_state_next  = ST_READY;
                end
            end
            default: w_state_next = ST_READY;
        endcase
    end

    // Stall-counter next value and the registered app_rdy it feeds.
    always_comb begin
        w_stall_cnt_next = '0;
        w_stall_next     = 1'b0;
        if ((STALL_PERIOD > 0) && w_calib_next) begin
            if (r_calib_done && (r_stall_cnt != SW'(STALL_PERIOD - 1))) begin
                w_stall_cnt_next = r_stall_cnt + 1'b1;
            end
            w_stall_next = (w_stall_cnt_next == SW'(STALL_PERIOD - 1));
        end
        w_app_rdy_next = w_calib_next && (w_state_next == ST_READY) && !w_stall_next;
    end

    // Calibration, stall and ready registers plus the command-channel state.
    always_ff @(posedge ui_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (ui_clk_sync_rst) begin
            r_calib_cnt  <= '0;
            r_calib_done <= 1'b0;
            r_stall_cnt  <= '0;
            r_app_rdy    <= 1'b0;
            r_state      <= ST_READY;
            r_pend_line  <= '0;
        end else begin
            if (!r_calib_done) begin
                r_calib_cnt <= r_calib_cnt + 1'b1;
            end
            r_calib_done <= w_calib_next;
            r_stall_cnt  <= w_stall_cnt_next;
            r_app_rdy    <= w_app_rdy_next;
            r_state      <= w_state_next;
            r_pend_line  <= w_pend_line_next;
        end
    end

    // Write-data FIFO pointers and occupancy; push and pop may share an edge.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_fifo_wp  <= 1'b0;
            r_fifo_rp  <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_wp <= ~r_fifo_wp;
            end
            if (w_pop) begin
                r_fifo_rp <= ~r_fifo_rp;
            end
            r_fifo_cnt <= r_fifo_cnt + 2'(w_push) - 2'(w_pop);
        end
    end

    // Write-data FIFO storage.
    always_ff @(posedge ui_clk) begin
        // NOTE: storage arrays (FIFO entries, memory lines) are not reset;
        // the pointers and counters above define what is valid, and the
        // memory must keep its contents across reset.
        if (w_push) begin
            r_fifo_data[r_fifo_wp] <= app.app_wdf_data;
            r_fifo_mask[r_fifo_wp] <= app.app_wdf_mask;
        end
    end

    // Byte-masked line update; a set mask bit leaves that byte untouched.
    always_ff @(posedge ui_clk) begin
        if (w_commit) begin
            for (int b = 0; b < 16; b++) begin
                if (!w_commit_mask[b]) begin
                    r_mem[w_commit_line][b*8 +: 8] <= w_commit_data[b*8 +: 8];
                end
            end
        end
    end

    // Read pipeline: capture the line on acceptance, shift RD_LATENCY stages.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_rd_vld[i] <= 1'b0;
                r_rd_dat[i] <= '0;
            end
        end else begin
            r_rd_vld[0] <= w_rd_cmd;
            r_rd_dat[0] <= w_rd_cmd ? r_mem[w_line] : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_vld[i] <= r_rd_vld[i-1];
                r_rd_dat[i] <= r_rd_dat[i-1];
            end
        end
    end

    assign app.app_rdy             = r_app_rdy;
    assign app.app_wdf_rdy         = w_wdf_rdy;
    assign app.init_calib_complete = r_calib_done;
    assign app.app_rd_data_valid   = r_rd_vld[RD_LATENCY-1];
    assign app.app_rd_data_end     = r_rd_vld[RD_LATENCY-1];
    assign app.app_rd_data         = r_rd_vld[RD_LATENCY-1] ? r_rd_dat[RD_LATENCY-1] : '0;
endmodule

// File: tb/tb_mig_app_model.sv
// Self-checking bench for mig_app_model: directed scenarios plus a random
// phase, compared every cycle against a queue-based reference model.
module tb_mig_app_model;
    localparam int MEM_DEPTH = 1024;
    localparam int CALIB     = 16;
    localparam int RD_LAT    = 4;
    localparam int STALL     = 4;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  m;
    } beat_t;

    typedef struct {
        int           due;
        logic [127:0] d;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mig_app_model_if app_if ();
    mig_app_model_if stall_if ();

    mig_app_model #(
        .MEM_DEPTH(MEM_DEPTH), .CALIB_CYCLES(CALIB), .RD_LATENCY(RD_LAT), .STALL_PERIOD(0)
    ) dut (
        .ui_clk(clk), .ui_clk_sync_rst(rst), .app(app_if)
    );

    mig_app_model #(
        .MEM_DEPTH(MEM_DEPTH), .CALIB_CYCLES(CALIB), .RD_LATENCY(RD_LAT), .STALL_PERIOD(STALL)
    ) dut_stall (
        .ui_clk(clk), .ui_clk_sync_rst(rst), .app(stall_if)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [127:0] mem_m [int];
    beat_t        fq[$];
    rd_t          rdq[$];
    bit           pend;
    int           pend_line;
    int           edges;
    int           cyc;

    // Stall-instance tally over the first 40 calibrated cycles.
    int s2_n;
    int s2_low;
    int s2_adj;
    bit s2_prev_low;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_write(input int line, input beat_t b);
        logic [127:0] t;
        t = mem_m[line];
        for (int i = 0; i < 16; i++) begin
            if (!b.m[i]) t[i*8 +: 8] = b.d[i*8 +: 8];
        end
        mem_m[line] = t;
    endtask

    // One clock cycle: drive inputs, advance the model across the edge,
    // then compare every output at the following falling edge.
    task automatic step(input bit en, input logic [2:0] cmd, input logic [26:0] addr,
                        input bit wren, input logic [127:0] wd, input logic [15:0] wm,
                        input bit wend, input bit do_rst);
        bit    m_calib, m_rdy, m_wrdy, beat, acc, exp_v;
        int    line;
        beat_t b;
        rd_t   r;
        logic [127:0] exp_d;
        app_if.app_en        = en;
        app_if.app_cmd       = cmd;
        app_if.app_addr      = addr;
        app_if.app_wdf_wren  = wren;
        app_if.app_wdf_data  = wd;
        app_if.app_wdf_mask  = wm;
        app_if.app_wdf_end   = wend;
        rst                  = do_rst;
        m_calib = (edges >= CALIB);
        m_rdy   = m_calib && !pend;
        m_wrdy  = m_calib && (fq.size() < 2);
        @(posedge clk);
        cyc++;
        if (do_rst) begin
            fq.delete();
            rdq.delete();
            pend  = 1'b0;
            edges = 0;
        end else begin
            edges++;
            beat = wren && m_wrdy;
            acc  = en && m_rdy;
            line = int'(addr >> 4) % MEM_DEPTH;
            b.d  = wd;
            b.m  = wm;
            if (acc && cmd == 3'b001) begin
                r.due = cyc - 1 + RD_LAT;
                r.d   = mem_m[line];
                rdq.push_back(r);
            end
            if (pend && beat) begin
                model_write(pend_line, b);
                pend = 1'b0;
            end else if (acc && cmd == 3'b000) begin
                if (fq.size() > 0) begin
                    model_write(line, fq.pop_front());
                    if (beat) fq.push_back(b);
                end else if (beat) begin
                    model_write(line, b);
                end else begin
                    pend      = 1'b1;
                    pend_line = line;
                end
            end else if (beat) begin
                fq.push_back(b);
            end
        end
        @(negedge clk);
        m_calib = (edges >= CALIB);
        check("calib", app_if.init_calib_complete, m_calib);
        check("app_rdy", app_if.app_rdy, m_calib && !pend);
        check("wdf_rdy", app_if.app_wdf_rdy, m_calib && (fq.size() < 2));
        exp_v = 1'b0;
        exp_d = '0;
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            exp_v = 1'b1;
            exp_d = rdq[0].d;
            void'(rdq.pop_front());
        end
        check("rd_valid", app_if.app_rd_data_valid, exp_v);
        check("rd_end", app_if.app_rd_data_end, exp_v);
        check("rd_data", app_if.app_rd_data, exp_d);
        if (!m_calib) begin
            check("stall_rdy_precal", stall_if.app_rdy, 1'b0);
        end else if (s2_n < 40) begin
            s2_n++;
            if (!stall_if.app_rdy) begin
                s2_low++;
                if (s2_prev_low) s2_adj++;
            end
            s2_prev_low = !stall_if.app_rdy;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 3'b000, '0, 0, '0, '0, 1, 0);
    endtask

    task automatic cmd_only(input logic [2:0] cmd, input logic [26:0] addr);
        step(1, cmd, addr, 0, '0, '0, 1, 0);
    endtask

    task automatic beat_only(input logic [127:0] d, input logic [15:0] m);
        step(0, 3'b000, '0, 1, d, m, 1, 0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] pat;
        logic [127:0] held;
        logic [26:0]  ra;
        int           sel;

        pend = 0; pend_line = 0; edges = 0; cyc = 0;
        s2_n = 0; s2_low = 0; s2_adj = 0; s2_prev_low = 0;
        stall_if.app_en = 0; stall_if.app_cmd = '0; stall_if.app_addr = '0;
        stall_if.app_wdf_wren = 0; stall_if.app_wdf_data = '0;
        stall_if.app_wdf_mask = '0; stall_if.app_wdf_end = 0;

        // Reset, then calibration: ready flags must rise exactly 16 cycles later.
        for (int i = 0; i < 3; i++) step(0, 3'b000, '0, 0, '0, '0, 1, 1);
        idle(CALIB + 1);

        // Fill lines 0..15 with a beat and write command in the same cycle.
        for (int l = 0; l < 16; l++) begin
            step(1, 3'b000, 27'(l << 4), 1, rand128(), 16'h0000, 1, 0);
        end

        // Masked beat queued first, then write to 0x40 pops it, then read back.
        for (int i = 0; i < 16; i++) pat[i*8 +: 8] = 8'(i);
        beat_only(pat, 16'hFFF0);
        cmd_only(3'b000, 27'h40);
        cmd_only(3'b001, 27'h40);
        idle(RD_LAT + 2);

        // Write to 0x80 with no data: app_rdy low until the late beat.
        cmd_only(3'b000, 27'h80);
        idle(2);
        beat_only(rand128(), 16'h0000);
        cmd_only(3'b001, 27'h80);
        idle(RD_LAT + 2);

        // Four back-to-back reads.
        for (int l = 0; l < 4; l++) cmd_only(3'b001, 27'(l << 4));
        idle(RD_LAT + 2);

        // Three beats, no commands: the third is held until a write pops one.
        held = rand128();
        beat_only(rand128(), 16'h0000);
        beat_only(rand128(), 16'h00FF);
        beat_only(held, 16'h0000);
        step(1, 3'b000, 27'h50, 1, held, 16'h0000, 1, 0);
        step(0, 3'b000, '0, 1, held, 16'h0000, 1, 0);
        // Unknown command with a queued beat: ignored, FIFO untouched.
        cmd_only(3'b111, 27'h60);
        cmd_only(3'b000, 27'h60);
        cmd_only(3'b000, 27'h70);
        // Aliased address: upper bits and byte offset ignored (line 5).
        cmd_only(3'b001, 27'h400_005B);
        cmd_only(3'b001, 27'h60);
        cmd_only(3'b001, 27'h70);
        idle(RD_LAT + 2);

        // Random traffic over lines 0..15 with aliased upper and low bits.
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            ra  = {13'($urandom), 6'b0, 4'($urandom_range(0, 15)), 4'($urandom)};
            step($urandom_range(0, 3) != 0,
                 (sel < 4) ? 3'b000 : (sel < 8) ? 3'b001 : 3'($urandom_range(2, 7)),
                 ra, $urandom_range(0, 1) == 1, rand128(), 16'($urandom),
                 $urandom_range(0, 3) != 0, 0);
        end
        idle(RD_LAT + 4);

        // Stall instance: one low app_rdy cycle per STALL cycles, never adjacent.
        check("stall_window", 128'(s2_n), 128'(40));
        check("stall_lows", 128'(s2_low), 128'(40 / STALL));
        check("stall_adjacent", 128'(s2_adj), 128'(0));

        // Reset with two reads in flight: no valid afterwards, memory retained.
        cmd_only(3'b001, 27'h40);
        cmd_only(3'b001, 27'h10);
        step(0, 3'b000, '0, 0, '0, '0, 1, 1);
        step(0, 3'b000, '0, 0, '0, '0, 1, 1);
        idle(CALIB + 1);
        cmd_only(3'b001, 27'h40);
        cmd_only(3'b001, 27'h50);
        idle(RD_LAT + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
